// File: rtl/cm0_ahb_pkg.sv
// Shared AHB-Lite definitions: bridge FSM states, HTRANS/HSIZE encodings
// and the transfer-size helper.
package cm0_ahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Index of the last byte of a transfer (N-1); sizes above a word act as a word.
  function automatic logic [2:0] size_last(input logic [2:0] hsize);
    case (hsize)
      HSIZE_BYTE: return 3'd0;
      HSIZE_HALF: return 3'd1;
      default:    return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/ahb_to_byte_sram.sv
// AHB-Lite slave bridging 8/16/32-bit transfers onto a byte-wide synchronous
// SRAM, one byte per cycle, inserting wait states as needed.
module ahb_to_byte_sram
  import cm0_ahb_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic              SRAMCS,
  output logic              SRAMWEN,
  output logic [ADDR_W-1:0] SRAMADDR,
  output logic [7:0]        SRAMWDATA,
  input  logic [7:0]        SRAMRDATA
);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [2:0]        last;
  logic [ADDR_W-1:0] base;
  logic [31:0]       rd_lanes;
  logic              accept, load, done_rd;
  logic [ADDR_W-1:0] byte_addr;
  logic [1:0]        lane, prev_lane;
  logic              unused_bits;

  assign unused_bits = ^{HADDR[31:ADDR_W], HTRANS[0]};

  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign byte_addr = base + ADDR_W'(cnt);
  assign lane      = byte_addr[1:0];
  // The byte returning from the SRAM this cycle was addressed one count earlier.
  assign prev_lane = lane - 2'd1;
  assign done_rd   = (state == ST_READ) && (cnt == last + 3'd1);

  assign HRESP     = 1'b0;
  assign SRAMADDR  = byte_addr;
  assign SRAMWDATA = HWDATA[{lane, 3'b000} +: 8];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    HREADYOUT = 1'b1;
    SRAMCS    = 1'b0;
    SRAMWEN   = 1'b0;
    case (state)
      ST_IDLE: load = accept;
      ST_WRITE: begin
        SRAMCS  = 1'b1;
        SRAMWEN = 1'b1;
        if (cnt == last) begin
          load      = accept;
          state_nxt = ST_IDLE;
        end else begin
          HREADYOUT = 1'b0;
          cnt_nxt   = cnt + 3'd1;
        end
      end
      ST_READ: begin
        if (done_rd) begin
          load      = accept;
          state_nxt = ST_IDLE;
        end else begin
          SRAMCS    = 1'b1;
          HREADYOUT = 1'b0;
          cnt_nxt   = cnt + 3'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A transfer accepted on a completion cycle starts immediately, no idle gap.
    if (load) begin
      state_nxt = HWRITE ? ST_WRITE : ST_READ;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rd_lanes <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load)
        rd_lanes <= '0;
      else if (state == ST_READ && cnt != 3'd0 && !done_rd)
        rd_lanes[{prev_lane, 3'b000} +: 8] <= SRAMRDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (load) begin
      last <= size_last(HSIZE);
      base <= HADDR[ADDR_W-1:0] & ~ADDR_W'(size_last(HSIZE));
    end
  end

  // Final byte bypasses the lane register so the read completes without an extra cycle.
  always_comb begin
    HRDATA = rd_lanes;
    if (done_rd)
      HRDATA[{prev_lane, 3'b000} +: 8] = SRAMRDATA;
  end

endmodule
